// File: rtl/apb_cfg_pkg.sv
// Shared types and helpers for the APB3 config initiator.
package apb_cfg_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_mst_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              err;
      logic              timeout;
   } apb_cfg_rsp_t;

   // Width of a saturating counter that must hold values 0..cycles, never narrower than 1 bit.
   function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
      int unsigned w;
      w = $clog2(cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/apb_cfg_master.sv
// APB3 initiator: one request in, one APB transfer out, one response back; a single transfer in flight.
module apb_cfg_master
   import apb_cfg_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH = 12,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
   input  logic                      req_write_i,
   input  logic [DATA_W-1:0]         req_wdata_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [DATA_W-1:0]         rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      rsp_timeout_o,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_W-1:0]         PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [DATA_W-1:0]         PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   localparam int unsigned      CNT_W    = tmo_cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic             TMO_EN   = (TIMEOUT_CYCLES != 0);

   apb_mst_state_e            state_q, state_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0]         pwdata_q, pwdata_d;
   logic                      pwrite_q, pwrite_d;
   logic                      psel_q, psel_d;
   logic                      penable_q, penable_d;
   logic                      rsp_valid_q, rsp_valid_d;
   apb_cfg_rsp_t              rsp_q, rsp_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;

   // Word alignment drops the byte-lane bits of the request address.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr_i[1:0];

   // Next-state and next-register values for the whole transfer sequence.
   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      rsp_valid_d = rsp_valid_q;
      rsp_d       = rsp_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               paddr_d  = {req_addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
               pwdata_d = req_wdata_i;
               pwrite_d = req_write_i;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               // Completion wins over a timeout landing in the same cycle.
               rsp_d.rdata   = (pwrite_q || PSLVERR) ? '0 : PRDATA;
               rsp_d.err     = PSLVERR;
               rsp_d.timeout = 1'b0;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end else begin
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (TMO_EN && (cnt_q == CNT_LAST)) begin
                  rsp_d.rdata   = '0;
                  rsp_d.err     = 1'b1;
                  rsp_d.timeout = 1'b1;
                  psel_d        = 1'b0;
                  penable_d     = 1'b0;
                  rsp_valid_d   = 1'b1;
                  state_d       = RESP;
               end
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops the bus and discards any pending response.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= IDLE;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
         cnt_q       <= cnt_d;
      end
   end

   assign req_ready_o   = (state_q == IDLE);
   assign PADDR         = paddr_q;
   assign PWDATA        = pwdata_q;
   assign PWRITE        = pwrite_q;
   assign PSEL          = psel_q;
   assign PENABLE       = penable_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rsp_q.rdata;
   assign rsp_err_o     = rsp_q.err;
   assign rsp_timeout_o = rsp_q.timeout;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Directed bench for apb_cfg_master with an 8-cycle timeout.
module tb_apb_cfg_master;

   localparam int unsigned AW = 12;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic          req_valid_i, req_ready_o, req_write_i;
   logic [AW-1:0] req_addr_i;
   logic [31:0]   req_wdata_i;
   logic          rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
   logic [31:0]   rsp_rdata_o;
   logic [AW-1:0] PADDR;
   logic [31:0]   PWDATA, PRDATA;
   logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

   int checks = 0;
   int errors = 0;

   apb_cfg_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // One request through SETUP/ACCESS/RESP; PREADY rises on ACCESS cycle waits+1, bp = response stall cycles.
   task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                       input int waits, input logic [31:0] prdata, input logic slverr, input int bp,
                       input logic [31:0] exp_rdata, input logic exp_err, input logic exp_tmo,
                       input int exp_acc);
      logic [AW-1:0] exp_addr;
      int            acc;
      exp_addr = {addr[AW-1:2], 2'b00};
      @(negedge HCLK);
      check("req_ready_idle", req_ready_o, 1);
      req_valid_i = 1'b1; req_addr_i = addr; req_write_i = wr; req_wdata_i = wdata;
      rsp_ready_i = (bp == 0);
      @(negedge HCLK);
      req_valid_i = 1'b0; req_addr_i = ~addr; req_wdata_i = ~wdata; req_write_i = ~wr;
      check("setup_psel", PSEL, 1);
      check("setup_penable", PENABLE, 0);
      check("setup_paddr", PADDR, exp_addr);
      check("setup_pwrite", PWRITE, wr);
      check("setup_pwdata", PWDATA, wdata);
      check("req_ready_busy", req_ready_o, 0);
      PRDATA = prdata; PSLVERR = slverr;
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge HCLK);
         if (!PENABLE) break;
         acc++;
         check("access_psel", PSEL, 1);
         check("access_paddr", PADDR, exp_addr);
         check("access_pwdata", PWDATA, wdata);
         check("access_rsp_valid", rsp_valid_o, 0);
         PREADY = (acc == waits + 1);
      end
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
      check("access_cycles", acc, exp_acc);
      check("resp_psel", PSEL, 0);
      check("resp_valid", rsp_valid_o, 1);
      check("resp_rdata", rsp_rdata_o, exp_rdata);
      check("resp_err", rsp_err_o, exp_err);
      check("resp_timeout", rsp_timeout_o, exp_tmo);
      check("resp_req_ready", req_ready_o, 0);
      if (bp > 0) begin
         for (int i = 0; i < bp; i++) begin
            req_valid_i = 1'b1;
            @(negedge HCLK);
            check("bp_valid", rsp_valid_o, 1);
            check("bp_rdata", rsp_rdata_o, exp_rdata);
            check("bp_err", rsp_err_o, exp_err);
            check("bp_timeout", rsp_timeout_o, exp_tmo);
            check("bp_req_ready", req_ready_o, 0);
            check("bp_psel", PSEL, 0);
         end
         rsp_ready_i = 1'b1;
      end
      @(negedge HCLK);
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b0;
      check("post_rsp_valid", rsp_valid_o, 0);
      check("post_req_ready", req_ready_o, 1);
      check("post_psel", PSEL, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESETn = 1'b0;
      req_valid_i = 1'b0; req_addr_i = '0; req_write_i = 1'b0; req_wdata_i = '0;
      rsp_ready_i = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      #12;
      check("rst_psel", PSEL, 0);
      check("rst_penable", PENABLE, 0);
      check("rst_pwrite", PWRITE, 0);
      check("rst_paddr", PADDR, 0);
      check("rst_pwdata", PWDATA, 0);
      check("rst_rsp_valid", rsp_valid_o, 0);
      check("rst_rdata", rsp_rdata_o, 0);
      check("rst_err", rsp_err_o, 0);
      check("rst_timeout", rsp_timeout_o, 0);
      check("rst_req_ready", req_ready_o, 1);
      @(negedge HCLK);
      HRESETn = 1'b1;

      // addr, wr, wdata, waits, prdata, slverr, bp, exp_rdata, exp_err, exp_tmo, exp_acc
      xfer(12'h004, 1'b1, 32'h1C00_0080, 0,   32'h55AA_55AA, 1'b0, 0, 32'h0,         1'b0, 1'b0, 1);
      xfer(12'h0C6, 1'b0, 32'h0,         3,   32'h0000_0002, 1'b0, 0, 32'h0000_0002, 1'b0, 1'b0, 4);
      xfer(12'h010, 1'b0, 32'h0,         0,   32'hDEAD_BEEF, 1'b1, 0, 32'h0,         1'b1, 1'b0, 1);
      xfer(12'h020, 1'b0, 32'h0,         100, 32'h1234_5678, 1'b0, 0, 32'h0,         1'b1, 1'b1, 8);
      xfer(12'h024, 1'b0, 32'h0,         7,   32'hCAFE_F00D, 1'b0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 8);
      xfer(12'h3FF, 1'b1, 32'hA5A5_0F0F, 1,   32'hFFFF_FFFF, 1'b0, 5, 32'h0,         1'b0, 1'b0, 2);
      xfer(12'hFFF, 1'b0, 32'h0,         0,   32'h0000_0001, 1'b0, 0, 32'h0000_0001, 1'b0, 1'b0, 1);

      // Reset in the middle of ACCESS
      @(negedge HCLK);
      req_valid_i = 1'b1; req_addr_i = 12'h100; req_write_i = 1'b0;
      @(negedge HCLK);
      req_valid_i = 1'b0;
      @(negedge HCLK);
      @(negedge HCLK);
      check("midrst_pre_penable", PENABLE, 1);
      #2 HRESETn = 1'b0;
      #1;
      check("midrst_psel", PSEL, 0);
      check("midrst_penable", PENABLE, 0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK);
         check("midrst_rsp_valid", rsp_valid_o, 0);
         check("midrst_req_ready", req_ready_o, 1);
         check("midrst_psel_idle", PSEL, 0);
      end

      xfer(12'h008, 1'b0, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
